gsim_param: RTL and testbench

Parametrised Gauss-Seidel solver engine, the successor to the fixed 16x16 GSIM. It solves up to i_matrix_num independent N x N systems A·x = b stored in matrix memory. For each system it runs ITER Gauss-Seidel sweeps and writes the N solution elements to the x result port. It sits between the matrix memory and the result buffer and is started by i_module_en.

---
 rtl/gsim_param.sv | 260 ++++++++++++++++++++++++++
 tb/tb_gsim_param.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_param.sv
// Parametrised Gauss-Seidel engine: for each matrix, loads b and A (diagonal
// holds the reciprocal), runs ITER in-place sweeps and streams out x.
module gsim_param #(
    parameter int N     = 16,
    parameter int DW    = 16,
    parameter int XW    = 32,
    parameter int FRAC  = 16,
    parameter int RFRAC = 14,
    parameter int ITER  = 16,
    parameter int AW    = 10,
    parameter int XAW   = 9,
    parameter int ACCW  = 56
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_module_en,
    input  logic [4:0]      i_matrix_num,
    output logic            o_proc_done,
    output logic            o_mem_rreq,
    output logic [AW-1:0]   o_mem_addr,
    input  logic            i_mem_rrdy,
    input  logic [N*DW-1:0] i_mem_dout,
    input  logic            i_mem_dout_vld,
    output logic            o_x_wen,
    output logic [XAW-1:0]  o_x_addr,
    output logic [XW-1:0]   o_x_data,
    output logic [2:0]      o_dbg_state
);

    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int WIW = $clog2(N + 1);
    localparam int SW  = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int MW  = DW + XW;
    localparam int PW  = ACCW + DW;

    localparam logic signed [PW-1:0] XMAX_W = {{(PW-XW+1){1'b0}}, {(XW-1){1'b1}}};
    localparam logic signed [PW-1:0] XMIN_W = {{(PW-XW+1){1'b1}}, {(XW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_REQ, S_LOAD_WAIT, S_MAC, S_UPDATE, S_OUT, S_NEXT, S_DONE
    } state_t;

    state_t                  state_q;
    logic [IW-1:0]           row_q;
    logic [IW-1:0]           col_q;
    logic [WIW-1:0]          widx_q;
    logic [SW-1:0]           sweep_q;
    logic [4:0]              m_q;
    logic [4:0]              num_q;
    logic [AW-1:0]           rd_addr_q;
    logic [XAW-1:0]          xa_q;
    logic signed [ACCW-1:0]  acc_q;
    logic signed [XW-1:0]    x_q [N];
    logic signed [DW-1:0]    b_q [N];
    logic signed [DW-1:0]    a_q [N][N];

    logic                    proc_done_q;
    logic                    mem_rreq_q;
    logic [AW-1:0]           mem_addr_q;
    logic                    x_wen_q;
    logic [XAW-1:0]          x_addr_q;
    logic [XW-1:0]           x_data_q;

    logic signed [DW-1:0]    a_sel;
    logic signed [XW-1:0]    x_sel;
    logic signed [DW-1:0]    r_sel;
    logic signed [MW-1:0]    mac_a;
    logic signed [MW-1:0]    mac_x;
    logic signed [MW-1:0]    mac_p;
    logic signed [ACCW-1:0]  acc_mac_d;
    logic signed [PW-1:0]    upd_a;
    logic signed [PW-1:0]    upd_r;
    logic signed [PW-1:0]    upd_p;
    logic signed [PW-1:0]    upd_s;
    logic signed [XW-1:0]    x_upd_d;

    // b_i scaled into the accumulator's Q.FRAC format
    function automatic logic signed [ACCW-1:0] acc_init(input logic signed [DW-1:0] b);
        acc_init = {{(ACCW-DW){b[DW-1]}}, b} << FRAC;
    endfunction

    always_comb begin
        a_sel     = a_q[row_q][col_q];
        x_sel     = x_q[col_q];
        mac_a     = {{XW{a_sel[DW-1]}}, a_sel};
        mac_x     = {{DW{x_sel[XW-1]}}, x_sel};
        mac_p     = mac_a * mac_x;
        acc_mac_d = acc_q - {{(ACCW-MW){mac_p[MW-1]}}, mac_p};
    end

    // x_i = sat((acc * r_i) >>> RFRAC); the arithmetic shift floors toward -inf
    always_comb begin
        r_sel = a_q[row_q][row_q];
        upd_a = {{DW{acc_q[ACCW-1]}}, acc_q};
        upd_r = {{(PW-DW){r_sel[DW-1]}}, r_sel};
        upd_p = upd_a * upd_r;
        upd_s = upd_p >>> RFRAC;
        if (upd_s > XMAX_W) begin
            x_upd_d = {1'b0, {(XW-1){1'b1}}};
        end else if (upd_s < XMIN_W) begin
            x_upd_d = {1'b1, {(XW-1){1'b0}}};
        end else begin
            x_upd_d = upd_s[XW-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            widx_q      <= '0;
            sweep_q     <= '0;
            m_q         <= '0;
            num_q       <= '0;
            rd_addr_q   <= '0;
            xa_q        <= '0;
            acc_q       <= '0;
            proc_done_q <= 1'b0;
            mem_rreq_q  <= 1'b0;
            mem_addr_q  <= '0;
            x_wen_q     <= 1'b0;
            x_addr_q    <= '0;
            x_data_q    <= '0;
            for (int k = 0; k < N; k++) begin
                x_q[k] <= '0;
            end
        end else begin
            proc_done_q <= 1'b0;
            x_wen_q     <= 1'b0;
            x_addr_q    <= '0;
            x_data_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (i_module_en) begin
                        num_q     <= i_matrix_num;
                        m_q       <= '0;
                        rd_addr_q <= '0;
                        xa_q      <= '0;
                        if (i_matrix_num != 5'd0) begin
                            widx_q     <= '0;
                            mem_rreq_q <= 1'b1;
                            mem_addr_q <= '0;
                            state_q    <= S_LOAD_REQ;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_LOAD_REQ: begin
                    if (i_mem_rrdy) begin
                        mem_rreq_q <= 1'b0;
                        rd_addr_q  <= rd_addr_q + 1'b1;
                        state_q    <= S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                    if (i_mem_dout_vld) begin
                        if (widx_q == WIW'(N)) begin
                            for (int k = 0; k < N; k++) begin
                                x_q[k] <= '0;
                            end
                            row_q   <= '0;
                            col_q   <= '0;
                            sweep_q <= '0;
                            acc_q   <= acc_init(b_q[0]);
                            state_q <= S_MAC;
                        end else begin
                            widx_q     <= widx_q + 1'b1;
                            mem_rreq_q <= 1'b1;
                            mem_addr_q <= rd_addr_q;
                            state_q    <= S_LOAD_REQ;
                        end
                    end
                end
                S_MAC: begin
                    if (col_q != row_q) begin
                        acc_q <= acc_mac_d;
                    end
                    if (col_q == IW'(N - 1)) begin
                        col_q   <= '0;
                        state_q <= S_UPDATE;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                S_UPDATE: begin
                    x_q[row_q] <= x_upd_d;
                    if (row_q == IW'(N - 1)) begin
                        row_q <= '0;
                        if (sweep_q == SW'(ITER - 1)) begin
                            state_q <= S_OUT;
                        end else begin
                            sweep_q <= sweep_q + 1'b1;
                            acc_q   <= acc_init(b_q[0]);
                            state_q <= S_MAC;
                        end
                    end else begin
                        row_q   <= row_q + 1'b1;
                        acc_q   <= acc_init(b_q[row_q + IW'(1)]);
                        state_q <= S_MAC;
                    end
                end
                S_OUT: begin
                    x_wen_q  <= 1'b1;
                    x_addr_q <= xa_q;
                    x_data_q <= x_q[row_q];
                    xa_q     <= xa_q + 1'b1;
                    if (row_q == IW'(N - 1)) begin
                        row_q   <= '0;
                        state_q <= S_NEXT;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                S_NEXT: begin
                    m_q <= m_q + 5'd1;
                    if ((m_q + 5'd1) == num_q) begin
                        state_q <= S_DONE;
                    end else begin
                        widx_q     <= '0;
                        mem_rreq_q <= 1'b1;
                        mem_addr_q <= rd_addr_q;
                        state_q    <= S_LOAD_REQ;
                    end
                end
                S_DONE: begin
                    proc_done_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Word 0 is b; word r+1 is row r of A
    always_ff @(posedge i_clk) begin
        if (state_q == S_LOAD_WAIT && i_mem_dout_vld) begin
            for (int k = 0; k < N; k++) begin
                if (widx_q == '0) begin
                    b_q[k] <= i_mem_dout[k*DW +: DW];
                end
                for (int r = 0; r < N; r++) begin
                    if (widx_q == WIW'(r + 1)) begin
                        a_q[r][k] <= i_mem_dout[k*DW +: DW];
                    end
                end
            end
        end
    end

    assign o_proc_done = proc_done_q;
    assign o_mem_rreq  = mem_rreq_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_x_wen     = x_wen_q;
    assign o_x_addr    = x_addr_q;
    assign o_x_data    = x_data_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_gsim_param.sv
// Bench for gsim_param: memory responder, write/read scoreboards, directed matrices.
module tb_gsim_param;
    localparam int N   = 16;
    localparam int DW  = 16;
    localparam int XW  = 32;
    localparam int AW  = 10;
    localparam int XAW = 9;
    localparam int EW  = 1 + XAW + XW;

    logic            i_clk;
    logic            i_reset;
    logic            i_module_en;
    logic [4:0]      i_matrix_num;
    logic            o_proc_done;
    logic            o_mem_rreq;
    logic [AW-1:0]   o_mem_addr;
    logic            i_mem_rrdy;
    logic [N*DW-1:0] i_mem_dout;
    logic            i_mem_dout_vld;
    logic            o_x_wen;
    logic [XAW-1:0]  o_x_addr;
    logic [XW-1:0]   o_x_data;
    logic [2:0]      o_dbg_state;

    logic [N*DW-1:0] mem [0:(1<<AW)-1];
    logic [EW-1:0]   exp_q[$];
    logic [AW-1:0]   rd_exp_q[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int stall_cyc = 0;
    int vld_dly = 1;

    gsim_param dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_module_en    (i_module_en),
        .i_matrix_num   (i_matrix_num),
        .o_proc_done    (o_proc_done),
        .o_mem_rreq     (o_mem_rreq),
        .o_mem_addr     (o_mem_addr),
        .i_mem_rrdy     (i_mem_rrdy),
        .i_mem_dout     (i_mem_dout),
        .i_mem_dout_vld (i_mem_dout_vld),
        .o_x_wen        (o_x_wen),
        .o_x_addr       (o_x_addr),
        .o_x_data       (o_x_data),
        .o_dbg_state    (o_dbg_state)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // memory model: rrdy after stall_cyc cycles, data valid vld_dly cycles after accept
    initial begin
        logic [AW-1:0] ra;
        i_mem_rrdy = 1'b0;
        i_mem_dout_vld = 1'b0;
        i_mem_dout = '0;
        forever begin
            if (o_mem_rreq === 1'b1 && i_reset === 1'b0) begin
                repeat (stall_cyc) @(negedge i_clk);
                i_mem_rrdy = 1'b1;
                ra = o_mem_addr;
                @(negedge i_clk);
                i_mem_rrdy = 1'b0;
                repeat (vld_dly - 1) @(negedge i_clk);
                i_mem_dout = mem[ra];
                i_mem_dout_vld = 1'b1;
                @(negedge i_clk);
                i_mem_dout_vld = 1'b0;
                i_mem_dout = '0;
            end else begin
                @(negedge i_clk);
            end
        end
    end

    // monitor: read handshake, write scoreboard, done pulse
    logic          prev_rreq = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_done = 1'b0;
    always begin
        logic [EW-1:0] e;
        logic [XW-1:0] ed;
        logic [XAW-1:0] ea;
        logic [AW-1:0] ra;
        longint diff;
        @(posedge i_clk);
        #1;
        if (i_reset) begin
            prev_rreq = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_rreq) begin
                if (i_mem_rrdy) begin
                    check("rreq_drop", {63'd0, o_mem_rreq}, 64'd0);
                    checks++;
                    if (rd_exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_read addr=%0d", prev_addr);
                    end else begin
                        ra = rd_exp_q.pop_front();
                        if (prev_addr !== ra) begin
                            errors++;
                            $display("FAIL read_addr act=%0d exp=%0d", prev_addr, ra);
                        end
                    end
                end else begin
                    checks++;
                    if (o_mem_rreq !== 1'b1 || o_mem_addr !== prev_addr) begin
                        errors++;
                        $display("FAIL rreq_hold rreq=%b addr=%0d exp_addr=%0d", o_mem_rreq, o_mem_addr, prev_addr);
                    end
                end
            end
            prev_rreq = o_mem_rreq;
            prev_addr = o_mem_addr;

            if (o_x_wen) begin
                wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d data=%h", o_x_addr, o_x_data);
                end else begin
                    e = exp_q.pop_front();
                    ea = e[XW +: XAW];
                    ed = e[XW-1:0];
                    diff = longint'($signed(o_x_data)) - longint'($signed(ed));
                    if (o_x_addr !== ea || (e[EW-1] ? (diff > 1 || diff < -1) : (o_x_data !== ed))) begin
                        errors++;
                        $display("FAIL x_write act addr=%0d data=%h exp addr=%0d data=%h", o_x_addr, o_x_data, ea, ed);
                    end
                end
            end else begin
                checks++;
                if (o_x_addr !== '0 || o_x_data !== '0) begin
                    errors++;
                    $display("FAIL x_idle addr=%0d data=%h exp 0", o_x_addr, o_x_data);
                end
            end

            if (o_proc_done) begin
                done_cnt++;
                checks++;
                if (prev_done || exp_q.size() != 0 || rd_exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL done_pulse prev=%b pending_wr=%0d pending_rd=%0d exp 0/0/0", prev_done, exp_q.size(), rd_exp_q.size());
                end
            end
            prev_done = o_proc_done;
        end
    end

    // memory builders
    task automatic set_elem(input int addr, input int k, input logic [DW-1:0] v);
        mem[addr][k*DW +: DW] = v;
    endtask

    task automatic build_diag(input int base);
        for (int k = 0; k < N; k++) set_elem(base, k, 16'h0004);
        for (int i = 0; i < N; i++) set_elem(base + 1 + i, i, 16'h2000);
    endtask

    task automatic build_coupled(input int base);
        set_elem(base, 0, 16'd5);
        set_elem(base, 1, 16'd5);
        set_elem(base + 1, 0, 16'h1000);
        set_elem(base + 1, 1, 16'd1);
        set_elem(base + 2, 0, 16'd1);
        set_elem(base + 2, 1, 16'h1000);
        for (int i = 2; i < N; i++) set_elem(base + 1 + i, i, 16'h4000);
    endtask

    task automatic build_sat(input int base);
        for (int k = 0; k < N; k++) set_elem(base, k, (k % 2 == 0) ? 16'h7FFF : 16'h8000);
        for (int i = 0; i < N; i++) set_elem(base + 1 + i, i, 16'h7FFF);
    endtask

    // expectation builders
    task automatic push_write(input int a, input logic [XW-1:0] d, input logic tol);
        exp_q.push_back({tol, XAW'(a), d});
    endtask

    task automatic push_reads(input int base);
        for (int w = 0; w <= N; w++) rd_exp_q.push_back(AW'(base + w));
    endtask

    task automatic expect_diag(input int xb);
        for (int i = 0; i < N; i++) push_write(xb + i, 32'h0002_0000, 1'b0);
    endtask

    task automatic expect_coupled(input int xb);
        for (int i = 0; i < N; i++) push_write(xb + i, (i < 2) ? 32'h0001_0000 : 32'h0, (i < 2));
    endtask

    task automatic expect_sat(input int xb);
        for (int i = 0; i < N; i++) push_write(xb + i, (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0);
    endtask

    // driver: start a job, optionally disturb inputs, wait for done
    task automatic run_job(input logic [4:0] num, input int budget, input bit disturb);
        int d0;
        bit seen;
        d0 = done_cnt;
        @(negedge i_clk);
        i_module_en = 1'b1;
        i_matrix_num = num;
        @(negedge i_clk);
        i_module_en = 1'b0;
        if (disturb) begin
            repeat (10) @(negedge i_clk);
            i_matrix_num = 5'd1;
            i_module_en = 1'b1;
            @(negedge i_clk);
            i_module_en = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge i_clk);
            if (done_cnt != d0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout act=none exp=done within %0d cycles", budget);
        end
        repeat (5) @(negedge i_clk);
        check("done_once", 64'(done_cnt - d0), 64'd1);
        check("writes_drained", 64'(exp_q.size()), 64'd0);
        check("reads_drained", 64'(rd_exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        int w0;
        bit hit;
        i_reset = 1'b1;
        i_module_en = 1'b0;
        i_matrix_num = '0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        build_diag(0);
        build_coupled(17);
        build_sat(34);

        repeat (3) @(negedge i_clk);
        check("rst_done", {63'd0, o_proc_done}, 64'd0);
        check("rst_rreq", {63'd0, o_mem_rreq}, 64'd0);
        check("rst_maddr", 64'(o_mem_addr), 64'd0);
        check("rst_wen", {63'd0, o_x_wen}, 64'd0);
        check("rst_xaddr", 64'(o_x_addr), 64'd0);
        check("rst_xdata", 64'(o_x_data), 64'd0);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("idle_state", 64'(o_dbg_state), 64'd0);

        // diagonal system, immediate handshake
        stall_cyc = 0;
        vld_dly = 1;
        expect_diag(0);
        push_reads(0);
        run_job(5'd1, 6000, 1'b0);

        // same system under memory backpressure
        stall_cyc = 5;
        vld_dly = 3;
        expect_diag(0);
        push_reads(0);
        run_job(5'd1, 7000, 1'b0);

        // three matrices: diagonal, coupled, saturating; late input changes ignored
        stall_cyc = 0;
        vld_dly = 1;
        expect_diag(0);
        expect_coupled(16);
        expect_sat(32);
        push_reads(0);
        push_reads(17);
        push_reads(34);
        run_job(5'd3, 16000, 1'b1);

        // zero matrices: done two cycles after the enable
        d0 = done_cnt;
        @(negedge i_clk);
        i_module_en = 1'b1;
        i_matrix_num = 5'd0;
        @(negedge i_clk);
        i_module_en = 1'b0;
        check("zero_no_done_yet", 64'(done_cnt - d0), 64'd0);
        @(negedge i_clk);
        check("zero_done_pulse", {63'd0, o_proc_done}, 64'd1);
        check("zero_done_count", 64'(done_cnt - d0), 64'd1);
        @(negedge i_clk);
        check("zero_done_drop", {63'd0, o_proc_done}, 64'd0);

        // abort during matrix 1 compute
        d0 = done_cnt;
        w0 = wr_cnt;
        expect_diag(0);
        push_reads(0);
        push_reads(17);
        @(negedge i_clk);
        i_module_en = 1'b1;
        i_matrix_num = 5'd2;
        @(negedge i_clk);
        i_module_en = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 6000 && !hit; c++) begin
            @(negedge i_clk);
            if (wr_cnt - w0 >= N) hit = 1'b1;
        end
        check("abort_m0_writes", 64'(wr_cnt - w0), 64'(N));
        repeat (300) @(negedge i_clk);
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (o_dbg_state == 3'd3) hit = 1'b1;
            else @(negedge i_clk);
        end
        check("abort_in_mac", {63'd0, hit}, 64'd1);
        check("abort_reads_done", 64'(rd_exp_q.size()), 64'd0);
        #2;
        i_reset = 1'b1;
        #1;
        check("abort_done", {63'd0, o_proc_done}, 64'd0);
        check("abort_rreq", {63'd0, o_mem_rreq}, 64'd0);
        check("abort_maddr", 64'(o_mem_addr), 64'd0);
        check("abort_wen", {63'd0, o_x_wen}, 64'd0);
        check("abort_xaddr", 64'(o_x_addr), 64'd0);
        check("abort_xdata", 64'(o_x_data), 64'd0);
        check("abort_state", 64'(o_dbg_state), 64'd0);
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        w0 = wr_cnt;
        repeat (200) @(negedge i_clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_no_writes", 64'(wr_cnt - w0), 64'd0);

        // restart reproduces the diagonal result
        expect_diag(0);
        push_reads(0);
        run_job(5'd1, 6000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
